// File: rtl/stream_select_mux_if.sv
// Stream bundle for stream_select_mux: NUM_CH producer channels in, one consumer out.
//   in_data   : flattened channel data, channel i at [i*WIDTH +: WIDTH]
//   in_valid  : per-channel valid
//   in_ready  : per-channel ready (combinational from the mux)
//   out_data  : registered selected word
//   out_valid : registered output valid
//   out_ready : consumer ready
//   grant     : registered source channel of out_data
// master = producers/consumer side, slave = the mux.
interface stream_select_mux_if #(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 4
);
  localparam int SEL_W = $clog2(NUM_CH);

  logic [NUM_CH*WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]       in_valid;
  logic [NUM_CH-1:0]       in_ready;
  logic [WIDTH-1:0]        out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [SEL_W-1:0]        grant;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, grant
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, grant
  );
endinterface

// File: rtl/stream_select_mux.sv
// Registered N-channel x W-bit stream multiplexer with valid/ready handshakes.
// Selection is either by external address (mode=0) or fair round-robin among
// requesting channels (mode=1).
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   mode    : 0 = address mode, 1 = round-robin mode
//   address : channel select in address mode
//   bus     : stream bundle (slave side), see stream_select_mux_if
module stream_select_mux #(
  parameter int  WIDTH  = 8,
  parameter int  NUM_CH = 4,
  localparam int SEL_W  = $clog2(NUM_CH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             mode,
  input  logic [SEL_W-1:0] address,
  stream_select_mux_if.slave bus
);

  localparam int unsigned         NCH       = NUM_CH;
  localparam logic [SEL_W:0]      NUM_CH_W  = (SEL_W+1)'(NUM_CH);
  localparam logic [SEL_W-1:0]    LAST_INIT = SEL_W'(NUM_CH - 1);

  logic [WIDTH-1:0] out_data_q;
  logic             out_valid_q;
  logic [SEL_W-1:0] grant_q;
  logic [SEL_W-1:0] last_q;

  logic             load_en;
  logic             win_found;
  logic [SEL_W-1:0] win_idx;
  logic [SEL_W-1:0] scan_idx;
  logic [WIDTH-1:0] sel_data;
  logic             sel_valid;
  logic             take;

  assign load_en = !out_valid_q || bus.out_ready;

  // Winner: address mode uses the address regardless of in_valid; round-robin
  // scans last+1, last+2, ... and takes the first requesting channel.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    if (!mode) begin
      if ({1'b0, address} < NUM_CH_W) begin
        win_found = 1'b1;
        win_idx   = address;
      end
    end else begin
      for (int unsigned k = 1; k <= NCH; k++) begin
        scan_idx = SEL_W'((32'(last_q) + k) % NCH);
        if (!win_found && bus.in_valid[scan_idx]) begin
          win_found = 1'b1;
          win_idx   = scan_idx;
        end
      end
    end
  end

  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (SEL_W'(i) == win_idx) begin
        sel_data  = bus.in_data[i*WIDTH +: WIDTH];
        sel_valid = bus.in_valid[i];
      end
    end
  end

  // Ready is forced low during reset because the pointer already names a winner.
  always_comb begin
    bus.in_ready = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      bus.in_ready[i] = reset_n && load_en && win_found && (win_idx == SEL_W'(i));
    end
  end

  assign take = reset_n && load_en && win_found && sel_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      grant_q     <= '0;
      last_q      <= LAST_INIT;
    end else if (take) begin
      out_data_q  <= sel_data;
      out_valid_q <= 1'b1;
      grant_q     <= win_idx;
      if (mode) begin
        last_q <= win_idx;
      end
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.grant     = grant_q;

endmodule

// File: tb/tb_stream_select_mux.sv
// Directed self-checking bench for stream_select_mux (WIDTH=8, NUM_CH=4).
module tb_stream_select_mux;

  localparam int WIDTH  = 8;
  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  logic             clk;
  logic             reset_n;
  logic             mode;
  logic [SEL_W-1:0] address;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] chd [4];

  stream_select_mux_if #(.WIDTH(WIDTH), .NUM_CH(NUM_CH)) bus ();

  stream_select_mux #(.WIDTH(WIDTH), .NUM_CH(NUM_CH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .mode    (mode),
    .address (address),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [7:0] d, input logic [1:0] g,
                           input logic v);
    check({tag, " out_data"},  32'(bus.out_data),  32'(d));
    check({tag, " grant"},     32'(bus.grant),     32'(g));
    check({tag, " out_valid"}, 32'(bus.out_valid), 32'(v));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    chd[0] = 8'hAA; chd[1] = 8'hBB; chd[2] = 8'hCC; chd[3] = 8'hDD;

    // Reset held with all channels requesting
    reset_n      = 1'b0;
    mode         = 1'b1;
    address      = 2'd0;
    bus.in_data  = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
    bus.in_valid = 4'b1111;
    bus.out_ready = 1'b1;
    tick();
    tick();
    check_out("reset", 8'h00, 2'd0, 1'b0);
    check("reset in_ready", 32'(bus.in_ready), 32'b0000);

    // Release: round-robin starts at channel 0
    reset_n = 1'b1;
    #1;
    check("rr first in_ready", 32'(bus.in_ready), 32'b0001);

    // Full-throughput round robin 0,1,2,3,0
    for (int k = 0; k < 5; k++) begin
      tick();
      check_out($sformatf("rr step%0d", k), chd[k % 4], 2'(k % 4), 1'b1);
    end
    // pointer now 0, next candidate channel 1
    check("rr next in_ready", 32'(bus.in_ready), 32'b0010);

    // Address mode, address 2
    mode    = 1'b0;
    address = 2'd2;
    #1;
    check("addr in_ready", 32'(bus.in_ready), 32'b0100);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_out($sformatf("addr cyc%0d", k), 8'hCC, 2'd2, 1'b1);
    end

    // Address-mode ready independent of valid; no transfer drains output
    bus.in_valid = 4'b0000;
    #1;
    check("addr ready no valid", 32'(bus.in_ready), 32'b0100);
    tick();
    check_out("addr drain", 8'hCC, 2'd2, 1'b0);

    // Back to round robin: pointer retained at 0, so channel 1 wins
    mode         = 1'b1;
    bus.in_valid = 4'b1111;
    #1;
    check("bp pre in_ready", 32'(bus.in_ready), 32'b0010);
    tick();
    check_out("bp load", 8'hBB, 2'd1, 1'b1);
    bus.out_ready = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("bp in_ready%0d", k), 32'(bus.in_ready), 32'b0000);
      tick();
      check_out($sformatf("bp hold%0d", k), 8'hBB, 2'd1, 1'b1);
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp release in_ready", 32'(bus.in_ready), 32'b0100);
    tick();
    check_out("bp next", 8'hCC, 2'd2, 1'b1);

    // Move pointer to 1 via a lone request on channel 1
    bus.in_valid = 4'b0010;
    tick();
    check_out("sparse setup", 8'hBB, 2'd1, 1'b1);

    // Sparse: only channels 3 and 1 requesting -> 3,1,3
    bus.in_valid = 4'b1010;
    #1;
    check("sparse in_ready a", 32'(bus.in_ready), 32'b1000);
    tick();
    check_out("sparse g3", 8'hDD, 2'd3, 1'b1);
    check("sparse in_ready b", 32'(bus.in_ready), 32'b0010);
    tick();
    check_out("sparse g1", 8'hBB, 2'd1, 1'b1);
    check("sparse in_ready c", 32'(bus.in_ready), 32'b1000);
    tick();
    check_out("sparse g3b", 8'hDD, 2'd3, 1'b1);

    // Asynchronous reset between edges while holding a word
    bus.out_ready = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check_out("async reset", 8'h00, 2'd0, 1'b0);
    check("async reset in_ready", 32'(bus.in_ready), 32'b0000);
    #2;
    reset_n       = 1'b1;
    bus.in_valid  = 4'b1111;
    bus.out_ready = 1'b1;
    #1;
    check("post reset in_ready", 32'(bus.in_ready), 32'b0001);
    tick();
    check_out("post reset load", 8'hAA, 2'd0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
